cook_sequencer: RTL and testbench

COOK_SEQUENCER -- requirements
Module: cook_sequencer

---
 rtl/cook_pkg.sv | 35 +++
 rtl/bcd_timer.sv | 73 +++++++
 rtl/cook_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cook_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared definitions for the cook sequencer: state encoding, timing constants
// and keypad decode helpers.
package cook_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // clk cycles per cooking second (100 Hz clock)
  localparam int unsigned TICK_DIV     = 100;
  // length of the end-of-cook beep in clk cycles
  localparam int unsigned BEEP_CYCLES  = 300;
  // power-level duty window in cooking seconds
  localparam int unsigned POWER_WINDOW = 10;

  // True when exactly one digit key is pressed.
  function automatic logic key_is_onehot(input logic [9:0] k);
    return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  // Digit value of a one-hot key pattern.
  function automatic logic [3:0] key_digit(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_timer.sv
// Three-digit BCD remaining-time register (M:SS). Supports clear, keypad
// shift-in and a one-second decrement with tens/minutes borrow.
module bcd_timer (
  input  logic       clk,
  input  logic       clear,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] digit_i,
  input  logic       dec_i,
  output logic [3:0] minutes,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       last
);

  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

  // Next time value: clear, shift a digit in from the right, or count down.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    min_d  = min_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      min_d  = 4'd0;
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (load_i) begin
      // old minutes digit falls off the left; minutes never exceeds 9
      min_d  = (tens_q > 4'd9) ? 4'd9 : tens_q;
      tens_d = ones_q;
      ones_d = digit_i;
    end else if (dec_i && !zero) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else begin
        ones_d = 4'd9;
        if (tens_q != 4'd0) begin
          // tens entered above 5 simply count down
          tens_d = tens_q - 4'd1;
        end else begin
          tens_d = 4'd5;
          min_d  = min_q - 4'd1;
        end
      end
    end
  end

  // Time register with asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (clear) begin
      min_q  <= 4'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      min_q  <= min_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign minutes  = min_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad time entry, start/stop/door control,
// 1 s countdown, pause and end-of-cook beep.
// Optional feature: COOK_SEQUENCER_POWER_LEVEL_EN adds a power[3:0] input that
// duty-cycles mag_on within each POWER_WINDOW-second slice of cooking time.
module cook_sequencer
  import cook_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
  input  logic [3:0] power,
`endif
  output logic [3:0] minutes,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done_beep,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [9:0] key_prev_q;
  logic       startn_prev_q, stopn_prev_q;
  logic [6:0] presc_q, presc_d;
  logic [8:0] beep_q, beep_d;

  logic key_ok, start_edge, stop_edge, tick;
  logic t_clr, t_load, t_dec, t_zero, t_last;

  // a key counts only when coming from all-released to a single key
  assign key_ok     = (key_prev_q == 10'd0) && key_is_onehot(keypad);
  assign start_edge = startn_prev_q & ~startn;
  assign stop_edge  = stopn_prev_q & ~stopn;
  assign tick       = (presc_q == 7'(TICK_DIV - 1));

  bcd_timer u_timer (
    .clk      (clk),
    .clear    (clear),
    .clr_i    (t_clr),
    .load_i   (t_load),
    .digit_i  (key_digit(keypad)),
    .dec_i    (t_dec),
    .minutes  (minutes),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (t_zero),
    .last     (t_last)
  );

  // Next-state and timer commands; stop always takes priority over start.
  always_comb begin
    state_d = state_q;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          t_load  = 1'b1;
          state_d = SET;
        end
      end
      SET: begin
        if (stop_edge) begin
          t_clr   = 1'b1;
          state_d = IDLE;
        end else if (key_ok) begin
          t_load = 1'b1;
        end else if (start_edge && door_closed && !t_zero) begin
          state_d = COOK;
        end
      end
      COOK: begin
        if (stop_edge || !door_closed) begin
          state_d = PAUSE;
        end else if (tick) begin
          t_dec = 1'b1;
          if (t_last) state_d = DONE;
        end
      end
      PAUSE: begin
        if (stop_edge) begin
          t_clr   = 1'b1;
          state_d = IDLE;
        end else if (start_edge && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop_edge || key_ok || (beep_q == 9'(BEEP_CYCLES - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler runs only while staying in COOK, so every COOK entry starts at 0;
  // beep counter likewise runs only while staying in DONE.
  always_comb begin
    presc_d = 7'd0;
    beep_d  = 9'd0;
    if (state_q == COOK && state_d == COOK && !tick) presc_d = presc_q + 7'd1;
    if (state_q == DONE && state_d == DONE)          beep_d  = beep_q + 9'd1;
  end

  // State, edge-detect history and counters.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= IDLE;
      key_prev_q    <= 10'd0;
      startn_prev_q <= 1'b0;
      stopn_prev_q  <= 1'b0;
      presc_q       <= 7'd0;
      beep_q        <= 9'd0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= keypad;
      startn_prev_q <= startn;
      stopn_prev_q  <= stopn;
      presc_q       <= presc_d;
      beep_q        <= beep_d;
    end
  end

`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
  logic [3:0] win_q, win_d;
  logic [3:0] power_eff;

  assign power_eff = ((power == 4'd0) || (power > 4'd10)) ? 4'd10 : power;

  // Cooking-second position inside the current power window; held in PAUSE.
  always_comb begin
    win_d = win_q;
    if (state_q == COOK && t_dec) begin
      win_d = (win_q == 4'(POWER_WINDOW - 1)) ? 4'd0 : win_q + 4'd1;
    end else if (state_q != COOK && state_q != PAUSE) begin
      win_d = 4'd0;
    end
  end

  // Power window register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) win_q <= 4'd0;
    else       win_q <= win_d;
  end

  assign mag_on = (state_q == COOK) && door_closed && (win_q < power_eff);
`else
  // Door is sampled combinationally so opening it cuts the magnetron at once.
  assign mag_on = (state_q == COOK) && door_closed;
`endif

  assign done_beep = (state_q == DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed self-checking bench for cook_sequencer.
module tb_cook_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] keypad;
  logic       startn, stopn, door_closed;
  logic [3:0] minutes, sec_tens, sec_ones;
  logic       mag_on, done_beep;
  logic [2:0] state;
`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
  logic [3:0] power;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cook_sequencer dut (
    .clk         (clk),
    .clear       (clear),
    .keypad      (keypad),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
    .power       (power),
`endif
    .minutes     (minutes),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .mag_on      (mag_on),
    .done_beep   (done_beep),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance n clock edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] t_now();
    return {20'd0, minutes, sec_tens, sec_ones};
  endfunction

  task automatic press_key(input int d);
    keypad = 10'd1 << d;
    cyc(1);
    keypad = 10'd0;
    cyc(1);
  endtask

  // returns one time unit after the edge that acted on the start press
  task automatic press_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    clear = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
    power = 4'd3;
`endif
    cyc(2);
    check("rst_state", state, S_IDLE);
    check("rst_time", t_now(), 32'h000);
    check("rst_mag", mag_on, 0);
    check("rst_beep", done_beep, 0);
    clear = 1'b0;
    cyc(2);

    // basic 0:23 cook through DONE and beep
    press_key(2);
    check("k2_time", t_now(), 32'h002);
    check("k2_state", state, S_SET);
    press_key(3);
    check("k23_time", t_now(), 32'h023);
    press_start();
    check("cook_state", state, S_COOK);
    check("cook_mag", mag_on, 1);
    cyc(99);
    check("pre_tick_time", t_now(), 32'h023);
    cyc(1);
    check("first_tick_time", t_now(), 32'h022);
    cyc(2199);
    check("pre_done_state", state, S_COOK);
    check("pre_done_time", t_now(), 32'h001);
    cyc(1);
    check("done_state", state, S_DONE);
    check("done_time", t_now(), 32'h000);
    check("done_mag", mag_on, 0);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (done_beep) cnt++;
      cyc(1);
    end
    check("beep_cycles", cnt, 300);
    check("after_beep_state", state, S_IDLE);
    check("after_beep_beep", done_beep, 0);

    // start with door open does not cook; closing door alone does not start
    press_key(2);
    press_key(3);
    door_closed = 1'b0;
    press_start();
    check("door_open_state", state, S_SET);
    check("door_open_mag", mag_on, 0);
    door_closed = 1'b1;
    cyc(5);
    check("door_close_state", state, S_SET);
    press_stop();
    check("set_stop_state", state, S_IDLE);
    check("set_stop_time", t_now(), 32'h000);

    // door opened mid-cook pauses and resumes from the held time
    press_key(1);
    press_key(5);
    press_start();
    check("c15_state", state, S_COOK);
    cyc(50);
    door_closed = 1'b0;
    #1;
    check("door_cut_mag", mag_on, 0);
    cyc(1);
    check("pause_state", state, S_PAUSE);
    check("pause_time", t_now(), 32'h015);
    cyc(200);
    check("pause_hold_time", t_now(), 32'h015);
    door_closed = 1'b1;
    cyc(3);
    check("pause_door_only", state, S_PAUSE);
    press_start();
    check("resume_state", state, S_COOK);
    check("resume_time", t_now(), 32'h015);
    cyc(99);
    check("resume_pre_tick", t_now(), 32'h015);
    cyc(1);
    check("resume_tick", t_now(), 32'h014);
    press_stop();
    press_stop();
    check("c15_abort_state", state, S_IDLE);

    // minutes borrow 1:00 -> 0:59, stop/stop to IDLE
    press_key(1);
    press_key(0);
    press_key(0);
    check("k100_time", t_now(), 32'h100);
    press_start();
    cyc(100);
    check("borrow_min", t_now(), 32'h059);
    press_stop();
    check("stop_pause", state, S_PAUSE);
    press_stop();
    check("stop_idle", state, S_IDLE);
    check("stop_idle_time", t_now(), 32'h000);

    // tens above 5 count down normally: 0:80 -> 0:79
    press_key(8);
    press_key(0);
    press_start();
    cyc(100);
    check("tens80_tick", t_now(), 32'h079);
    press_stop();
    press_stop();

    // shift discards old minutes; multi-bit keys ignored; stop beats start
    press_key(1);
    press_key(2);
    press_key(3);
    press_key(4);
    check("shift_discard", t_now(), 32'h234);
    keypad = 10'b0000001100;
    cyc(1);
    keypad = 10'b0000000100;
    cyc(1);
    keypad = 10'd0;
    cyc(1);
    check("multikey_time", t_now(), 32'h234);
    check("multikey_state", state, S_SET);
    startn = 1'b0;
    stopn  = 1'b0;
    cyc(1);
    check("stop_wins_state", state, S_IDLE);
    check("stop_wins_time", t_now(), 32'h000);
    startn = 1'b1;
    stopn  = 1'b1;
    cyc(1);

    // start refused at 0:00
    press_key(0);
    press_start();
    check("zero_start_state", state, S_SET);
    press_stop();

    // key during DONE returns to IDLE without entering a digit
    press_key(1);
    press_start();
    cyc(100);
    check("d1_done_state", state, S_DONE);
    cyc(10);
    press_key(5);
    check("done_key_state", state, S_IDLE);
    check("done_key_time", t_now(), 32'h000);
    check("done_key_beep", done_beep, 0);

    // asynchronous clear mid-cook
    press_key(3);
    press_start();
    cyc(20);
    #2;
    clear = 1'b1;
    #1;
    check("aclr_state", state, S_IDLE);
    check("aclr_mag", mag_on, 0);
    check("aclr_time", t_now(), 32'h000);
    cyc(3);
    clear = 1'b0;
    cyc(2);
    press_start();
    check("aclr_resume_state", state, S_IDLE);
    cyc(1);

`ifdef COOK_SEQUENCER_POWER_LEVEL_EN
    // power 3 over 20 s: on for 3 of every 10 seconds
    press_key(2);
    press_key(0);
    press_start();
    cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      if (mag_on) cnt++;
      cyc(1);
    end
    check("power3_on_cycles", cnt, 600);
    check("power3_done", state, S_DONE);
    press_stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
